// File: rtl/lat_mem.sv
// lat_mem: word-addressed memory with a fixed-latency, credit-controlled, in-order response path.
// Optional build macro LAT_MEM_WRITE_ACK_EN: writes also return a response carrying the written data.
`default_nettype none

module lat_mem #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_op_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [DATA_W-1:0] req_write_data_in,
  output logic              rsp_valid_out,
  input  logic              rsp_ready_in,
  output logic [DATA_W-1:0] rsp_data_out
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

`ifdef LAT_MEM_WRITE_ACK_EN
  localparam logic WRITE_ACK = 1'b1;
`else
  localparam logic WRITE_ACK = 1'b0;
`endif

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [LATENCY-1:0] pipe_v;
  logic [DATA_W-1:0]  pipe_d [LATENCY];

  logic [DATA_W-1:0] rsp_buf [RSP_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [CNT_W-1:0]  credit;

  logic              accept;
  logic              produce;
  logic              push;
  logic              pop;
  logic              buf_nonempty;
  logic [DATA_W-1:0] rsp_src;

  // Ready depends only on the credit state and reset, so it never combinationally follows req_valid_in.
  assign req_ready_out = !reset && (credit < CNT_W'(RSP_DEPTH));
  assign accept        = req_valid_in && req_ready_out;
  assign produce       = accept && (!req_op_in || WRITE_ACK);
  assign rsp_src       = req_op_in ? req_write_data_in : mem[req_addr_in];

  assign buf_nonempty  = (wr_ptr != rd_ptr);
  assign rsp_valid_out = !reset && buf_nonempty;
  assign rsp_data_out  = rsp_valid_out ? rsp_buf[rd_ptr[PTR_W-1:0]] : '0;
  assign pop           = rsp_valid_out && rsp_ready_in;
  assign push          = pipe_v[LATENCY-1];

  // Array contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (accept && req_op_in) begin
      mem[req_addr_in] <= req_write_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= produce;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_d[0] <= rsp_src;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  // Credit limit guarantees a free slot whenever the pipe delivers, so push never checks fullness.
  always_ff @(posedge clk) begin
    if (push) begin
      rsp_buf[wr_ptr[PTR_W-1:0]] <= pipe_d[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({produce, pop})
        2'b10:   credit <= credit + CNT_W'(1);
        2'b01:   credit <= credit - CNT_W'(1);
        default: credit <= credit;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lat_mem.sv
// tb_lat_mem: randomized and directed scoreboard bench for lat_mem against a queue-based reference model.
`default_nettype none

module tb_lat_mem;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int LATENCY   = 2;
  localparam int RSP_DEPTH = 4;

`ifdef LAT_MEM_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              req_valid_in;
  logic              req_ready_out;
  logic              req_op_in;
  logic [ADDR_W-1:0] req_addr_in;
  logic [DATA_W-1:0] req_write_data_in;
  logic              rsp_valid_out;
  logic              rsp_ready_in;
  logic [DATA_W-1:0] rsp_data_out;

  lat_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out),
    .req_op_in(req_op_in),
    .req_addr_in(req_addr_in),
    .req_write_data_in(req_write_data_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_ready_in(rsp_ready_in),
    .rsp_data_out(rsp_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] sb [$];
  int acc_cnt  = 0;
  int hs_cnt   = 0;
  int n_cmp    = 0;
  int n_fail   = 0;
  bit last_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired, got timeout expected completion at %0t", name, $time);
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rsp_valid_in_reset", rsp_valid_out, 0);
        chk("rsp_data_in_reset", rsp_data_out, 0);
      end else if (rsp_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp_valid", rsp_valid_out, 0);
        end else begin
          chk("rsp_data", rsp_data_out, sb[0]);
          if (rsp_ready_in) begin
            void'(sb.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  // One clock: apply the model's acceptance rule to the inputs currently driven, then check ready.
  task automatic tick();
    bit model_ready;
    model_ready = !reset && ((acc_cnt - hs_cnt) < RSP_DEPTH);
    last_acc = req_valid_in && model_ready;
    if (last_acc) begin
      if (req_op_in) begin
        ref_mem[int'(req_addr_in)] = req_write_data_in;
        if (WACK) begin
          sb.push_back(req_write_data_in);
          acc_cnt++;
        end
      end else begin
        sb.push_back(ref_mem[int'(req_addr_in)]);
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      sb.delete();
      acc_cnt = 0;
      hs_cnt  = 0;
    end
    chk("req_ready", req_ready_out, !reset && ((acc_cnt - hs_cnt) < RSP_DEPTH));
  endtask

  task automatic send(input bit op, input int addr, input logic [DATA_W-1:0] d);
    req_valid_in      = 1'b1;
    req_op_in         = op;
    req_addr_in       = ADDR_W'(addr);
    req_write_data_in = d;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) timeout("send_accept");
    req_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) tick();
    if (sb.size() != 0) timeout("drain");
  endtask

  initial begin
    int n;
    int h0;
    reset = 1'b1;
    req_valid_in = 1'b0;
    req_op_in = 1'b0;
    req_addr_in = '0;
    req_write_data_in = '0;
    rsp_ready_in = 1'b0;
    repeat (3) tick();
    chk("ready_during_reset", req_ready_out, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_initial_reset", req_ready_out, 1);

    rsp_ready_in = 1'b1;
    for (int a = 0; a < 16; a++) send(1'b1, a, 32'hA000_0000 + 32'(a) * 32'h0101);
    drain();

    // Single read with latency check.
    send(1'b1, 5, 32'hDEAD_BEEF);
    drain();
    h0 = hs_cnt;
    send(1'b0, 5, 32'h0);
    for (int j = 1; j <= LATENCY; j++) begin
      tick();
      chk("read_latency_valid", rsp_valid_out, (j == LATENCY) ? 1 : 0);
    end
    drain();
    repeat (4) tick();
    chk("single_read_count", hs_cnt - h0, 1);

    // Write immediately followed by read of the same word.
    send(1'b1, 3, 32'h1234_5678);
    send(1'b0, 3, 32'h0);
    drain();

    // Backpressure: only RSP_DEPTH reads fit, then drain in order.
    rsp_ready_in = 1'b0;
    n = 0;
    req_op_in = 1'b0;
    for (int t = 0; t < 12; t++) begin
      req_valid_in = (n < 6);
      req_addr_in  = ADDR_W'(n);
      tick();
      if (last_acc) n++;
    end
    chk("bp_accepted", n, RSP_DEPTH);
    chk("bp_ready_low", req_ready_out, 0);
    rsp_ready_in = 1'b1;
    for (int t = 0; t < 60 && n < 6; t++) begin
      req_valid_in = 1'b1;
      req_addr_in  = ADDR_W'(n);
      tick();
      if (last_acc) n++;
    end
    if (n < 6) timeout("bp_remaining");
    req_valid_in = 1'b0;
    drain();

    // Mid-operation reset discards in-flight reads; memory survives.
    send(1'b1, 7, 32'h7777_A5A5);
    drain();
    rsp_ready_in = 1'b0;
    for (int a = 1; a <= 3; a++) send(1'b0, a, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready_in = 1'b1;
    tick();
    chk("ready_after_mid_reset", req_ready_out, 1);
    repeat (8) tick();
    chk("no_rsp_after_reset", rsp_valid_out, 0);
    send(1'b0, 7, 32'h0);
    drain();

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      req_valid_in      = ($urandom_range(0, 3) != 0);
      req_op_in         = $urandom_range(0, 1) == 1;
      req_addr_in       = ADDR_W'($urandom_range(0, 15));
      req_write_data_in = $urandom;
      rsp_ready_in      = ($urandom_range(0, 9) < 7);
      tick();
    end
    req_valid_in = 1'b0;
    rsp_ready_in = 1'b1;
    drain();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lat_mem.md
LAT_MEM -- requirements
Module: lat_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (memory depth 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter LATENCY, default 2, request-to-response register delay in cycles (legal 1..4).
REQ-004 SHALL have parameter RSP_DEPTH, default 4, response buffer entries and credit limit (power of 2, at least 2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid_in  input  1  request present.
REQ-008 SHALL have port req_ready_out  output  1  request can be accepted this cycle.
REQ-009 SHALL have port req_op_in  input  1  0 = read, 1 = write.
REQ-010 SHALL have port req_addr_in  input  ADDR_W  word address.
REQ-011 SHALL have port req_write_data_in  input  DATA_W  write data, ignored for reads.
REQ-012 SHALL have port rsp_valid_out  output  1  response present.
REQ-013 SHALL have port rsp_ready_in  input  1  consumer accepts response.
REQ-014 SHALL have port rsp_data_out  output  DATA_W  response data.

Function
REQ-015 SHALL accept a request on any rising edge where req_valid_in and req_ready_out are both 1; there is no other acceptance path.
REQ-016 SHALL commit a write to the array on its acceptance edge.
REQ-017 SHALL sample read data on the acceptance edge; for a write at edge k and a read at edge k+1 to the same address, the read returns the new data.
REQ-018 SHALL issue responses in request-acceptance order with no reordering.
REQ-019 SHALL present a response accepted at edge k, when the buffer is empty, as rsp_valid_out=1 from edge k+LATENCY.
REQ-020 SHALL hold a response, once presented, with stable rsp_data_out until the edge where rsp_valid_out and rsp_ready_in are both 1.
REQ-021 SHALL present the next buffered response, if any, in the cycle after that handshake; back-to-back throughput is one response per cycle.
REQ-022 SHALL maintain a credit count = responses in the delay pipe plus responses in the buffer, range 0..RSP_DEPTH.
REQ-023 SHALL drive req_ready_out = (credit count < RSP_DEPTH) and not reset; the output is registered or derived only from state, never from req_valid_in.
REQ-024 SHALL increment the count on acceptance of a response-producing request, decrement it on a response handshake, and leave it unchanged when both occur on the same edge.
REQ-025 SHALL, as a consequence of REQ-022 to REQ-024, never drop or overwrite a response: the buffer cannot overflow.
REQ-026 SHALL keep the buffer-empty condition (rsp_valid_out=0) with no effect when rsp_ready_in is 1 and no response is present.
REQ-027 SHALL have the response-buffer pointers wrap modulo RSP_DEPTH.

Reset
REQ-028 SHALL clear the delay pipe, buffer pointers and credit count while reset is 1.
REQ-029 SHALL drive rsp_valid_out=0, req_ready_out=0 and rsp_data_out=0 during reset.
REQ-030 SHALL drive req_ready_out=1 on the first cycle after reset deasserts.
REQ-031 SHALL discard in-flight responses on reset asserted mid-operation.
REQ-032 SHALL not clear memory array contents on reset.
REQ-033 SHALL let an already-committed write persist through reset.

Configuration
REQ-034 SHALL, with macro LAT_MEM_WRITE_ACK_EN defined, make writes produce a response whose rsp_data_out equals the written data, and make writes consume a credit.
REQ-035 SHALL, with LAT_MEM_WRITE_ACK_EN undefined, make writes produce no response and consume no credit, while still being gated by req_ready_out.

Verification
REQ-036 SHALL cover single read: reset, preload addr 5 = 0xDEADBEEF, read addr 5 accepted at edge k with rsp_ready_in=1 -> rsp_valid_out=1 with data 0xDEADBEEF from edge k+2, exactly one response.
REQ-037 SHALL cover write-then-read: write 0x12345678 to addr 3 at edge k, read addr 3 at edge k+1 -> read response 0x12345678; with LAT_MEM_WRITE_ACK_EN, a write-ack carrying 0x12345678 precedes it.
REQ-038 SHALL cover backpressure: rsp_ready_in=0 and 6 reads to addrs 0..5 offered -> exactly 4 accepted and req_ready_out=0 after them; raise rsp_ready_in -> data from addrs 0..3 in order, then the remaining 2 are accepted.
REQ-039 SHALL cover simultaneous events: count = 4, same edge has a response handshake and a new request presented -> no accept that edge (ready was 0); next edge accepts, count returns to 4.
REQ-040 SHALL cover mid-operation reset: 3 reads in flight, reset for 1 cycle -> no responses afterward, req_ready_out=1 on the cycle after reset, and a prior write to addr 7 still readable.
